reset_sequencer: RTL and testbench

Synthesizable, parametrised successor to the bench clock/reset generator. Runs from one clock and produces NUM_CH per-channel resets (ADC front-end, SAR logic, capture FIFO, ...) that are released in a staggered order after a hold time. It also generates a divided clock-enable strobe once all channels are out of reset. Supports a software re-sequence request, acknowledged on completion.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/ce_divider.sv | 35 +++
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staggered reset sequencer: FSM state encodings
// and the constant helper functions used to size its counters.
package reset_seq_pkg;

  localparam logic [1:0] HOLD       = 2'd0;
  localparam logic [1:0] RELEASE    = 2'd1;
  localparam logic [1:0] RUN        = 2'd2;
  localparam logic [1:0] ASSERT_SEQ = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Clock-enable strobe generator: while en is high, ce pulses once every DIV
// cycles, the first pulse DIV cycles after en is first seen high.
module ce_divider
  import reset_seq_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ce
);

  localparam int             CW       = clog2(DIV + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_ce;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
      r_ce  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      r_ce  <= 1'b0;
    end
  end

  assign ce = r_ce;

endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-channel reset sequencer with software re-sequence and a divided
// clock enable. Define RSTSEQ_ASSERT_STAGGER_EN to stagger assertion on sw_req.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int   NUM_CH         = 4,
  parameter int   HOLD_CYCLES    = 4,
  parameter int   STAGGER_CYCLES = 2,
  parameter int   DIV            = 2,
  parameter logic RESET_ACTIVE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_req,
  output logic              sw_ack,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              busy,
  output logic              done,
  output logic              ce
);

  localparam int              CW         = clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, DIV) + 1);
  localparam int              IW         = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   STAG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0]   LAST_CH    = IW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ALL_ACTIVE = {NUM_CH{RESET_ACTIVE}};
  localparam bit              SINGLE_CH  = (NUM_CH == 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [NUM_CH-1:0] r_ch_rst;
  logic              r_busy;
  logic              r_done;
  logic              r_sw_ack;
  logic              r_sw_pend;

  logic w_restart;
  logic w_last_release;
  logic w_ce_en;
  logic w_ce;

  assign w_restart      = (r_state == RUN) && sw_req;
  assign w_last_release = ((r_state == HOLD) && (r_cnt == HOLD_LAST) && SINGLE_CH) ||
                          ((r_state == RELEASE) && (r_cnt == STAG_LAST) && (r_idx == LAST_CH));
  // Masking with w_restart makes ce fall on the same edge as done.
  assign w_ce_en        = r_done && !w_restart;

  // NOTE: all state here uses non-blocking assignments, so the later
  // w_last_release block cleanly overrides the per-state updates above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_ch_rst  <= ALL_ACTIVE;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_sw_ack  <= 1'b0;
      r_sw_pend <= 1'b0;
    end else begin
      r_sw_ack <= 1'b0;
      case (r_state)
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt       <= '0;
            r_ch_rst[0] <= ~RESET_ACTIVE;
            r_idx       <= IW'(1);
            r_state     <= RELEASE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == STAG_LAST) begin
            r_cnt           <= '0;
            r_ch_rst[r_idx] <= ~RESET_ACTIVE;
            r_idx           <= r_idx + IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RUN: begin
          if (sw_req) begin
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_sw_pend <= 1'b1;
`ifdef RSTSEQ_ASSERT_STAGGER_EN
            r_ch_rst[LAST_CH] <= RESET_ACTIVE;
            r_idx             <= LAST_CH - IW'(1);
            r_state           <= SINGLE_CH ? HOLD : ASSERT_SEQ;
`else
            r_ch_rst <= ALL_ACTIVE;
            r_state  <= HOLD;
`endif
          end
        end
`ifdef RSTSEQ_ASSERT_STAGGER_EN
        ASSERT_SEQ: begin
          // Walk downwards; the hold period starts once channel 0 is asserted.
          if (r_cnt == STAG_LAST) begin
            r_cnt           <= '0;
            r_ch_rst[r_idx] <= RESET_ACTIVE;
            if (r_idx == '0) r_state <= HOLD;
            else             r_idx   <= r_idx - IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        default: r_state <= HOLD;
      endcase

      if (w_last_release) begin
        r_state   <= RUN;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_sw_ack  <= r_sw_pend;
        r_sw_pend <= 1'b0;
      end
    end
  end

  ce_divider #(.DIV(DIV)) u_ce_divider (
    .clk (clk),
    .rst (rst),
    .en  (w_ce_en),
    .ce  (w_ce)
  );

  assign ch_rst = r_ch_rst;
  assign busy   = r_busy;
  assign done   = r_done;
  assign sw_ack = r_sw_ack;
  assign ce     = w_ce;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus two single-channel
// instances (active-high and active-low resets); edges are numbered from 0.
module tb_reset_sequencer;

  localparam int N = 4;
  localparam int H = 4;
  localparam int S = 2;
  localparam int D = 2;
`ifdef RSTSEQ_ASSERT_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sw_req;
  logic [N-1:0] ch_rst;
  logic         busy, done, ce, sw_ack;
  logic [0:0]   mh_ch, ml_ch;
  logic         mh_busy, mh_done, mh_ce, mh_ack;
  logic         ml_busy, ml_done, ml_ce, ml_ack;

  int checks = 0;
  int errors = 0;
  int edge_n = -1;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .DIV(D), .RESET_ACTIVE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_ack(sw_ack),
    .ch_rst(ch_rst), .busy(busy), .done(done), .ce(ce)
  );

  reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .DIV(1), .RESET_ACTIVE(1'b1)) u_min_hi (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_ack(mh_ack),
    .ch_rst(mh_ch), .busy(mh_busy), .done(mh_done), .ce(mh_ce)
  );

  reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .DIV(1), .RESET_ACTIVE(1'b0)) u_min_lo (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_ack(ml_ack),
    .ch_rst(ml_ch), .busy(ml_busy), .done(ml_done), .ce(ml_ce)
  );

  function automatic int done_of(input int e, input bit stag);
    return e + (stag ? (N - 1) * S : 0) + H + (N - 1) * S;
  endfunction

  // Expected {ch_rst, busy, done, ce, sw_ack} n edges in, for reference edge e.
  function automatic logic [7:0] exp_main(input int n, input int e, input bit stag, input bit ack_ok);
    logic [N-1:0] ch;
    logic         dn, c, ak;
    int           ep, de, a_at;
    ep = stag ? e + (N - 1) * S : e;
    for (int i = 0; i < N; i++) begin
      a_at  = stag ? e + (N - 1 - i) * S : e;
      ch[i] = (n >= a_at) && (n < ep + H + i * S);
    end
    de = done_of(e, stag);
    dn = (n >= de);
    c  = (n >= de + D) && (((n - de) % D) == 0);
    ak = ack_ok && (n == de);
    return {ch, !dn, dn, c, ak};
  endfunction

  // Single-channel instances: rst ends at edge 3, sw_req sampled at edge 10.
  function automatic logic [7:0] exp_min(input int n, input logic ra);
    logic act;
    act = (n <= 3) || (n == 10);
    return {3'b000, act ? ra : ~ra, act, !act, (n >= 5 && n <= 9) || (n >= 12), n == 11};
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_n, obs, exp_v);
    end
  endtask

  initial begin
    int e, e1, d1, e2, d2;
    bit stg;
    rst    = 1'b1;
    sw_req = 1'b0;

    tick();
    check("reset_main", {ch_rst, busy, done, ce, sw_ack}, 8'b1111_1000);
    check("reset_min_hi", {3'b000, mh_ch, mh_busy, mh_done, mh_ce, mh_ack}, exp_min(0, 1'b1));
    check("reset_min_lo", {3'b000, ml_ch, ml_busy, ml_done, ml_ce, ml_ack}, exp_min(0, 1'b0));
    repeat (3) tick();
    rst = 1'b0;

    // rst-initiated sequence from edge 3; sw_req at edge 10 while busy is ignored.
    while (edge_n < 19) begin
      sw_req = (edge_n == 9);
      tick();
      check("seq_rst", {ch_rst, busy, done, ce, sw_ack}, exp_main(edge_n, 3, 1'b0, 1'b0));
      if (edge_n <= 12) begin
        check("min_hi", {3'b000, mh_ch, mh_busy, mh_done, mh_ce, mh_ack}, exp_min(edge_n, 1'b1));
        check("min_lo", {3'b000, ml_ch, ml_busy, ml_done, ml_ce, ml_ack}, exp_min(edge_n, 1'b0));
      end
    end

    // Software re-sequence sampled at edge 20.
    while (edge_n < done_of(20, STAG) + 4) begin
      sw_req = (edge_n == 19);
      tick();
      check("seq_sw", {ch_rst, busy, done, ce, sw_ack}, exp_main(edge_n, 20, STAG, 1'b1));
    end
    sw_req = 1'b0;

    // Fresh rst sequence, renumbered so its last rst edge is 3; rst again at edge 9.
    edge_n = -1;
    rst    = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    while (edge_n < 24) begin
      rst = (edge_n == 8);
      tick();
      check("seq_rst_mid", {ch_rst, busy, done, ce, sw_ack},
            exp_main(edge_n, (edge_n < 9) ? 3 : 9, 1'b0, 1'b0));
    end

    // rst with sw_req at 25 (rst wins); sw_req at 41 on a ce pulse; rst at 45 cancels the ack.
    while (edge_n < 59) begin
      rst    = (edge_n == 24) || (edge_n == 44);
      sw_req = (edge_n == 24) || (edge_n == 40);
      tick();
      stg = (edge_n >= 41) && (edge_n < 45);
      e   = (edge_n < 41) ? 25 : ((edge_n < 45) ? 41 : 45);
      check("seq_rst_prio", {ch_rst, busy, done, ce, sw_ack},
            exp_main(edge_n, e, stg ? STAG : 1'b0, stg));
    end
    rst = 1'b0;

    // sw_req held high: re-triggers on the edge after each completion.
    e1 = 60;
    d1 = done_of(e1, STAG);
    e2 = d1 + 1;
    d2 = done_of(e2, STAG);
    while (edge_n < d2 + 1) begin
      sw_req = (edge_n >= 59) && (edge_n < d2);
      tick();
      check("seq_sw_hold", {ch_rst, busy, done, ce, sw_ack},
            exp_main(edge_n, (edge_n < e2) ? e1 : e2, STAG, 1'b1));
    end
    sw_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
